// File: rtl/dfp_burst_adapter_pkg.sv
// rtl/dfp_burst_adapter_pkg.sv - shared types and default geometry for the DFP burst adapter
package dfp_burst_adapter_pkg;

    localparam int LINE_WIDTH_DEF   = 256;
    localparam int BEAT_WIDTH_DEF   = 64;
    localparam int ADDR_WIDTH_DEF   = 32;
    localparam int BURST_BEATS      = LINE_WIDTH_DEF / BEAT_WIDTH_DEF;
    localparam int LINE_OFFSET_BITS = $clog2(LINE_WIDTH_DEF / 8);

    typedef enum logic [2:0] {
        AD_IDLE,
        AD_RD_REQ,
        AD_RD_BURST,
        AD_WR_BURST,
        AD_RESP
    } adapter_state_t;

endpackage

// File: rtl/dfp_burst_adapter_if.sv
// rtl/dfp_burst_adapter_if.sv - line-request bus (dcache side) and burst bus (memory side)
interface dfp_line_if #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] dfp_addr;
    logic                  dfp_read;
    logic                  dfp_write;
    logic [LINE_WIDTH-1:0] dfp_wdata;
    logic [LINE_WIDTH-1:0] dfp_rdata;
    logic                  dfp_resp;

    modport master (output dfp_addr, dfp_read, dfp_write, dfp_wdata,
                    input  dfp_rdata, dfp_resp);
    modport slave  (input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
                    output dfp_rdata, dfp_resp);
endinterface

interface bmem_burst_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BEAT_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] bmem_addr;
    logic                  bmem_read;
    logic                  bmem_write;
    logic [BEAT_WIDTH-1:0] bmem_wdata;
    logic                  bmem_ready;
    logic [BEAT_WIDTH-1:0] bmem_rdata;
    logic                  bmem_rvalid;

    modport master (output bmem_addr, bmem_read, bmem_write, bmem_wdata,
                    input  bmem_ready, bmem_rdata, bmem_rvalid);
    modport slave  (input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
                    output bmem_ready, bmem_rdata, bmem_rvalid);
endinterface

// File: rtl/dfp_burst_adapter_line_deserializer.sv
// rtl/dfp_burst_adapter_line_deserializer.sv - line buffer with beat counter, beat write-in and beat select-out
module line_deserializer #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [LINE_WIDTH-1:0] line_i,
    input  logic                  beat_we_i,
    input  logic [BEAT_WIDTH-1:0] beat_i,
    input  logic                  adv_i,
    input  logic                  clr_i,
    output logic [LINE_WIDTH-1:0] line_nxt_o,
    output logic [BEAT_WIDTH-1:0] beat_o,
    output logic                  last_o
);
    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CW    = $clog2(BEATS);

    logic [BEATS-1:0][BEAT_WIDTH-1:0] line_q, line_d;
    logic [CW-1:0]                    beat_cnt_q, beat_cnt_d;

    always_comb begin
        line_d = line_q;
        if (load_i) begin
            line_d = line_i;
        end else if (beat_we_i) begin
            line_d[beat_cnt_q] = beat_i;
        end
    end

    // The counter is exactly log2(BEATS) wide so it wraps to 0 after the last beat.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (clr_i) begin
            beat_cnt_d = '0;
        end else if (beat_we_i || adv_i) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            line_q     <= line_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign line_nxt_o = line_d;
    assign beat_o     = line_q[beat_cnt_q];
    assign last_o     = (beat_cnt_q == CW'(BEATS - 1));

endmodule

// File: rtl/dfp_burst_adapter.sv
// rtl/dfp_burst_adapter.sv - converts whole-line dcache requests into fixed-length memory bursts
module dfp_burst_adapter
    import dfp_burst_adapter_pkg::*;
#(
    parameter int LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int BEAT_WIDTH = BEAT_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    dfp_line_if.slave     dfp,
    bmem_burst_if.master  bmem
);
    localparam int OFFS = $clog2(LINE_WIDTH / 8);

    adapter_state_t        state_q;
    logic [ADDR_WIDTH-1:0] bmem_addr_q;
    logic                  bmem_read_q;
    logic                  bmem_write_q;
    logic                  dfp_resp_q;
    logic [LINE_WIDTH-1:0] dfp_rdata_q;

    logic                  load;
    logic                  beat_we;
    logic                  adv;
    logic                  clr;
    logic [LINE_WIDTH-1:0] line_nxt;
    logic [BEAT_WIDTH-1:0] beat_out;
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] aligned_addr;

    assign aligned_addr = {dfp.dfp_addr[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};

    assign load    = (state_q == AD_IDLE) && dfp.dfp_write;
    assign beat_we = (state_q == AD_RD_BURST) && bmem.bmem_rvalid;
    assign adv     = (state_q == AD_WR_BURST) && bmem.bmem_ready;
    assign clr     = (state_q == AD_RD_REQ) || (state_q == AD_RESP);

    line_deserializer #(
        .LINE_WIDTH (LINE_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH)
    ) u_line (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .line_i     (dfp.dfp_wdata),
        .beat_we_i  (beat_we),
        .beat_i     (bmem.bmem_rdata),
        .adv_i      (adv),
        .clr_i      (clr),
        .line_nxt_o (line_nxt),
        .beat_o     (beat_out),
        .last_o     (last_beat)
    );

    // Requests are only sampled in IDLE, so a dropped request never aborts a burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= AD_IDLE;
            bmem_addr_q  <= '0;
            bmem_read_q  <= 1'b0;
            bmem_write_q <= 1'b0;
            dfp_resp_q   <= 1'b0;
            dfp_rdata_q  <= '0;
        end else begin
            case (state_q)
                AD_IDLE: begin
                    if (dfp.dfp_write) begin
                        bmem_addr_q  <= aligned_addr;
                        bmem_write_q <= 1'b1;
                        state_q      <= AD_WR_BURST;
                    end else if (dfp.dfp_read) begin
                        bmem_addr_q <= aligned_addr;
                        bmem_read_q <= 1'b1;
                        state_q     <= AD_RD_REQ;
                    end
                end
                AD_RD_REQ: begin
                    if (bmem.bmem_ready) begin
                        bmem_read_q <= 1'b0;
                        state_q     <= AD_RD_BURST;
                    end
                end
                AD_RD_BURST: begin
                    // Capture includes the final beat arriving this cycle.
                    if (bmem.bmem_rvalid && last_beat) begin
                        dfp_rdata_q <= line_nxt;
                        dfp_resp_q  <= 1'b1;
                        state_q     <= AD_RESP;
                    end
                end
                AD_WR_BURST: begin
                    if (bmem.bmem_ready && last_beat) begin
                        bmem_write_q <= 1'b0;
                        dfp_resp_q   <= 1'b1;
                        state_q      <= AD_RESP;
                    end
                end
                AD_RESP: begin
                    dfp_resp_q <= 1'b0;
                    state_q    <= AD_IDLE;
                end
                default: begin
                    bmem_read_q  <= 1'b0;
                    bmem_write_q <= 1'b0;
                    dfp_resp_q   <= 1'b0;
                    state_q      <= AD_IDLE;
                end
            endcase
        end
    end

    assign bmem.bmem_addr  = bmem_addr_q;
    assign bmem.bmem_read  = bmem_read_q;
    assign bmem.bmem_write = bmem_write_q;
    assign bmem.bmem_wdata = (state_q == AD_WR_BURST) ? beat_out : '0;
    assign dfp.dfp_resp    = dfp_resp_q;
    assign dfp.dfp_rdata   = dfp_rdata_q;

endmodule

// File: tb/tb_dfp_burst_adapter.sv
// tb/tb_dfp_burst_adapter.sv - scoreboard bench for dfp_burst_adapter
module tb_dfp_burst_adapter;
    import dfp_burst_adapter_pkg::*;

    localparam int LW = 256;
    localparam int BW = 64;
    localparam int AW = 32;
    localparam int NB = LW / BW;
    localparam logic [AW-1:0] ALIGN_MASK = ~32'h1F;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dfp_line_if   #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dfp_bus ();
    bmem_burst_if #(.ADDR_WIDTH(AW), .BEAT_WIDTH(BW)) bmem_bus ();

    dfp_burst_adapter #(
        .LINE_WIDTH (LW),
        .BEAT_WIDTH (BW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .dfp  (dfp_bus),
        .bmem (bmem_bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct { logic [AW-1:0] addr; logic [BW-1:0] data; } beat_t;
    typedef struct { bit is_rd; logic [LW-1:0] line; } resp_t;

    beat_t         exp_wr_q[$];
    resp_t         exp_resp_q[$];
    logic [AW-1:0] exp_rd_addr_q[$];
    logic [LW-1:0] mdl_rdata = '0;
    int            n_resp = 0, n_rdreq = 0, n_wbeat = 0, resp_cyc = -1;
    logic          stall_q = 1'b0;
    logic [BW-1:0] stall_data;
    logic [AW-1:0] stall_addr;
    beat_t         mon_b;
    resp_t         mon_r;

    always @(negedge clk) begin
        assert (!(dfp_bus.dfp_read && dfp_bus.dfp_write)) else $error("dcache drove read and write together");
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (bmem_bus.bmem_read || bmem_bus.bmem_write)
                chk("addr_low_bits", LW'(bmem_bus.bmem_addr[4:0]), '0);
            if (bmem_bus.bmem_read) begin
                n_rdreq++;
                if (bmem_bus.bmem_ready) begin
                    if (exp_rd_addr_q.size() == 0) chk("rd_req_unexpected", 1, 0);
                    else chk("rd_addr", LW'(bmem_bus.bmem_addr), LW'(exp_rd_addr_q.pop_front()));
                end
            end
            if (stall_q && bmem_bus.bmem_write) begin
                chk("wdata_stable", LW'(bmem_bus.bmem_wdata), LW'(stall_data));
                chk("waddr_stable", LW'(bmem_bus.bmem_addr), LW'(stall_addr));
            end
            stall_q    = bmem_bus.bmem_write && !bmem_bus.bmem_ready;
            stall_data = bmem_bus.bmem_wdata;
            stall_addr = bmem_bus.bmem_addr;
            if (bmem_bus.bmem_write && bmem_bus.bmem_ready) begin
                n_wbeat++;
                if (exp_wr_q.size() == 0) chk("wr_beat_unexpected", 1, 0);
                else begin
                    mon_b = exp_wr_q.pop_front();
                    chk("wr_addr", LW'(bmem_bus.bmem_addr), LW'(mon_b.addr));
                    chk("wr_data", LW'(bmem_bus.bmem_wdata), LW'(mon_b.data));
                end
            end
            if (dfp_bus.dfp_resp) begin
                n_resp++;
                resp_cyc = cyc;
                if (exp_resp_q.size() == 0) chk("resp_unexpected", 1, 0);
                else begin
                    mon_r = exp_resp_q.pop_front();
                    if (mon_r.is_rd) begin
                        chk("rd_line", dfp_bus.dfp_rdata, mon_r.line);
                        mdl_rdata = mon_r.line;
                    end else begin
                        chk("rdata_hold", dfp_bus.dfp_rdata, mdl_rdata);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] line,
                            input logic [15:0] pat, input int plen, input int exp_lat);
        int t, i, n0, guard;
        resp_t r;
        n0 = n_resp;
        t  = cyc;
        dfp_bus.dfp_addr  = a;
        dfp_bus.dfp_wdata = line;
        dfp_bus.dfp_write = 1'b1;
        for (int k = 0; k < NB; k++) exp_wr_q.push_back('{addr: a & ALIGN_MASK, data: line[k*BW +: BW]});
        r.is_rd = 1'b0;
        r.line  = '0;
        exp_resp_q.push_back(r);
        i = 0;
        guard = 0;
        forever begin
            tick();
            if (n_resp != n0) break;
            guard++;
            if (guard > 60) begin
                chk("wr_timeout", 0, 1);
                break;
            end
            bmem_bus.bmem_ready = (i < plen) ? pat[i] : 1'b1;
            i++;
        end
        dfp_bus.dfp_write   = 1'b0;
        bmem_bus.bmem_ready = 1'b1;
        chk("wr_resp_cycle", LW'(resp_cyc - t), LW'(exp_lat));
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] line,
                           input int o0, input int o1, input int o2, input int o3);
        int t, c, k, n0, nrq0;
        int offs[4];
        resp_t r;
        offs = '{o0, o1, o2, o3};
        n0   = n_resp;
        nrq0 = n_rdreq;
        t    = cyc;
        dfp_bus.dfp_addr = a;
        dfp_bus.dfp_read = 1'b1;
        exp_rd_addr_q.push_back(a & ALIGN_MASK);
        r.is_rd = 1'b1;
        r.line  = line;
        exp_resp_q.push_back(r);
        k = 0;
        c = 0;
        forever begin
            tick();
            c++;
            if (n_resp != n0) break;
            if (c > 60) begin
                chk("rd_timeout", 0, 1);
                break;
            end
            if (k < NB && c == offs[k]) begin
                bmem_bus.bmem_rvalid = 1'b1;
                bmem_bus.bmem_rdata  = line[k*BW +: BW];
                k++;
            end else begin
                bmem_bus.bmem_rvalid = 1'b0;
                bmem_bus.bmem_rdata  = {$urandom, $urandom};
            end
        end
        dfp_bus.dfp_read     = 1'b0;
        bmem_bus.bmem_rvalid = 1'b0;
        chk("rd_resp_cycle", LW'(resp_cyc - t), LW'(offs[3] + 1));
        chk("rd_req_cycles", LW'(n_rdreq - nrq0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] l1, l2, l3, l4w, l4r, l5, l6;
        int n0, nb0, t;

        rst = 1'b1;
        dfp_bus.dfp_addr     = '0;
        dfp_bus.dfp_read     = 1'b0;
        dfp_bus.dfp_write    = 1'b0;
        dfp_bus.dfp_wdata    = '0;
        bmem_bus.bmem_ready  = 1'b1;
        bmem_bus.bmem_rdata  = '0;
        bmem_bus.bmem_rvalid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_resp",   LW'(dfp_bus.dfp_resp), 0);
        chk("rst_bread",  LW'(bmem_bus.bmem_read), 0);
        chk("rst_bwrite", LW'(bmem_bus.bmem_write), 0);
        chk("rst_baddr",  LW'(bmem_bus.bmem_addr), 0);
        chk("rst_rdata",  dfp_bus.dfp_rdata, 0);
        chk("rst_wdata",  LW'(bmem_bus.bmem_wdata), 0);
        tick();

        // 1: read, consecutive beats
        l1 = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
        do_read(32'h1000_0020, l1, 2, 3, 4, 5);

        // 2: write, always ready, unaligned address
        l2 = {64'hDEAD_3333_3333_3333, 64'h2222_2222_2222_2222,
              64'h1111_1111_1111_1111, 64'h0000_0000_0000_BEEF};
        do_write(32'h2000_004C, l2, 16'h0, 0, 5);

        // 3: write, ready pattern 1,0,0,1,1,0,1
        l3 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        n0  = n_resp;
        nb0 = n_wbeat;
        do_write(32'h2100_0000, l3, 16'b1011001, 7, 8);
        chk("t3_beats", LW'(n_wbeat - nb0), 4);
        chk("t3_resps", LW'(n_resp - n0), 1);
        chk("t3_sb_empty", LW'(exp_wr_q.size()), 0);

        // 4: writeback then fetch back-to-back
        l4w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        l4r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        n0  = n_resp;
        do_write(32'h3000_0080, l4w, 16'h0, 0, 5);
        do_read(32'h3000_00A0, l4r, 2, 3, 4, 5);
        chk("t4_resps", LW'(n_resp - n0), 2);

        // 5: reset after two read beats
        l5 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        n0 = n_resp;
        t  = cyc;
        dfp_bus.dfp_addr = 32'h4000_0040;
        dfp_bus.dfp_read = 1'b1;
        exp_rd_addr_q.push_back(32'h4000_0040);
        tick();
        tick();
        bmem_bus.bmem_rvalid = 1'b1;
        bmem_bus.bmem_rdata  = l5[0 +: BW];
        tick();
        bmem_bus.bmem_rdata  = l5[BW +: BW];
        tick();
        rst = 1'b1;
        dfp_bus.dfp_read    = 1'b0;
        bmem_bus.bmem_rdata = l5[2*BW +: BW];
        tick();
        rst = 1'b0;
        bmem_bus.bmem_rdata = l5[3*BW +: BW];
        mdl_rdata = '0;
        @(negedge clk);
        chk("t5_resp",   LW'(dfp_bus.dfp_resp), 0);
        chk("t5_bread",  LW'(bmem_bus.bmem_read), 0);
        chk("t5_bwrite", LW'(bmem_bus.bmem_write), 0);
        chk("t5_baddr",  LW'(bmem_bus.bmem_addr), 0);
        chk("t5_rdata",  dfp_bus.dfp_rdata, 0);
        chk("t5_wdata",  LW'(bmem_bus.bmem_wdata), 0);
        chk("t5_elapsed", LW'(cyc - t), 5);
        tick();
        tick();
        bmem_bus.bmem_rvalid = 1'b0;
        tick();
        chk("t5_no_resp", LW'(n_resp - n0), 0);
        do_read(32'h4000_0040, l5, 2, 3, 4, 5);

        // 6: read with rvalid gaps, then stray rvalid while idle
        l6 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        do_read(32'h5000_0100, l6, 3, 7, 8, 12);
        n0 = n_resp;
        for (int i = 0; i < 3; i++) begin
            bmem_bus.bmem_rvalid = 1'b1;
            bmem_bus.bmem_rdata  = {$urandom, $urandom};
            tick();
        end
        bmem_bus.bmem_rvalid = 1'b0;
        repeat (3) tick();
        chk("t6_stray_resp", LW'(n_resp - n0), 0);
        chk("t6_rdata_hold", dfp_bus.dfp_rdata, l6);
        chk("sb_resp_empty", LW'(exp_resp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
